// File: rtl/kpn_pkg.sv
// ---------------------------------------------------------------------------
// kpn_pkg
//   Shared constants and types for the KPN channel FIFO between the
//   producer process and the LCD display consumer.
//   Contents:
//     KPN_WORD_W       width of one channel word (four BCD digits)
//     KPN_FIFO_DEPTH   default number of storage words (power of two)
//     KPN_AFULL_LEVEL  default occupancy at which almost_full asserts
//     kpn_word_t       one channel word
// ---------------------------------------------------------------------------
package kpn_pkg;

  localparam int KPN_WORD_W      = 16;
  localparam int KPN_FIFO_DEPTH  = 8;
  localparam int KPN_AFULL_LEVEL = 6;

  typedef logic [KPN_WORD_W-1:0] kpn_word_t;

endpackage : kpn_pkg

// File: rtl/kpn_fifo_channel_if.sv
// ---------------------------------------------------------------------------
// kpn_fifo_channel_if
//   Bundles the producer/consumer handshake of the KPN channel FIFO.
//   Modports:
//     master  the environment: drives wr, data_in, rd, clear_flags and
//             observes data_out, occupancy and status flags
//     slave   the FIFO itself
//   Signals:
//     wr, data_in        write strobe and write word
//     rd                 read strobe (pops the head word)
//     data_out           head word, first-word-fall-through, 0 when empty
//     full, empty        blocking conditions for the two processes
//     almost_full        count >= AFULL_LEVEL
//     count              occupancy, 0..DEPTH
//     overflow/underflow sticky protocol-violation flags
//     clear_flags        clears the sticky flags
// ---------------------------------------------------------------------------
interface kpn_fifo_channel_if
  import kpn_pkg::*;
#(
  parameter int WIDTH = KPN_WORD_W,
  parameter int DEPTH = KPN_FIFO_DEPTH
);

  logic                   wr;
  logic [WIDTH-1:0]       data_in;
  logic                   rd;
  logic [WIDTH-1:0]       data_out;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   underflow;
  logic                   clear_flags;

  modport master (
    output wr, data_in, rd, clear_flags,
    input  data_out, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd, clear_flags,
    output data_out, full, empty, almost_full, count, overflow, underflow
  );

endinterface : kpn_fifo_channel_if

// File: rtl/kpn_fifo_ram.sv
// ---------------------------------------------------------------------------
// kpn_fifo_ram
//   DEPTH x WIDTH register file backing the KPN channel FIFO.
//   One synchronous write port, one asynchronous read port. Contents are
//   never reset; the FIFO's empty flag masks stale words.
//   Ports:
//     clock   write clock (posedge)
//     we      write enable
//     waddr   write address
//     wdata   write data
//     raddr   read address
//     rdata   read data, combinational from raddr and storage
// ---------------------------------------------------------------------------
module kpn_fifo_ram
  import kpn_pkg::*;
#(
  parameter int WIDTH = KPN_WORD_W,
  parameter int DEPTH = KPN_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left without a reset so it can map onto plain
  // flops or distributed RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : kpn_fifo_ram

// File: rtl/kpn_fifo_channel.sv
// ---------------------------------------------------------------------------
// kpn_fifo_channel
//   Bounded first-word-fall-through FIFO forming one KPN channel between a
//   producer process and the LCD display consumer. full/empty provide KPN
//   blocking; sticky overflow/underflow record protocol violations.
//   Parameters:
//     WIDTH        word width in bits
//     DEPTH        storage words, power of two and >= 2
//     AFULL_LEVEL  almost_full threshold, 1..DEPTH
//   Ports:
//     clock  single clock, all logic on posedge
//     reset  synchronous, active-high; discards all queued words
//     ch     channel interface (slave modport): wr/data_in, rd/data_out,
//            full, empty, almost_full, count, overflow, underflow,
//            clear_flags
// ---------------------------------------------------------------------------
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int WIDTH       = KPN_WORD_W,
  parameter int DEPTH       = KPN_FIFO_DEPTH,
  parameter int AFULL_LEVEL = KPN_AFULL_LEVEL
) (
  input  logic               clock,
  input  logic               reset,
  kpn_fifo_channel_if.slave  ch
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  ptr_t             wr_ptr_q;
  ptr_t             rd_ptr_q;
  cnt_t             count_q;
  cnt_t             count_next;
  logic             full_q;
  logic             empty_q;
  logic             afull_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             wr_ok;
  logic             rd_ok;
  logic             ram_we;
  logic [WIDTH-1:0] ram_rdata;

  // Accept decisions use only registered state plus the strobes. A write
  // into a full FIFO is still taken when a read frees a slot in the same
  // cycle; a read of an empty FIFO is always refused, even alongside a
  // write, because the incoming word is not yet in storage.
  always_comb begin
    wr_ok      = ch.wr & (~full_q | ch.rd);
    rd_ok      = ch.rd & ~empty_q;
    count_next = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + cnt_t'(1);
      2'b01:   count_next = count_q - cnt_t'(1);
      default: count_next = count_q;
    endcase
  end

  // The write in a reset cycle must not land in storage; pointers are
  // being cleared anyway, but keeping the RAM quiet avoids surprises when
  // inspecting memory during debug.
  assign ram_we = wr_ok & ~reset;

  kpn_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (ch.data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Pointers and occupancy. The status flags are registered from the
  // next-state count, so they change on exactly the same edge as count
  // and never depend combinationally on wr or rd. Pointer wrap falls out
  // of the power-of-two DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      count_q <= count_next;
      full_q  <= (count_next == cnt_t'(DEPTH));
      empty_q <= (count_next == '0);
      afull_q <= (count_next >= cnt_t'(AFULL_LEVEL));
    end
  end

  // Sticky violation flags. A violation in the same cycle as clear_flags
  // leaves the flag set so no event is ever lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ch.wr & ~wr_ok) begin
        overflow_q <= 1'b1;
      end else if (ch.clear_flags) begin
        overflow_q <= 1'b0;
      end
      if (ch.rd & ~rd_ok) begin
        underflow_q <= 1'b1;
      end else if (ch.clear_flags) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // The head word is shown straight from storage; stale contents are
  // masked to zero while the channel is empty.
  assign ch.data_out    = empty_q ? '0 : ram_rdata;
  assign ch.full        = full_q;
  assign ch.empty       = empty_q;
  assign ch.almost_full = afull_q;
  assign ch.count       = count_q;
  assign ch.overflow    = overflow_q;
  assign ch.underflow   = underflow_q;

endmodule : kpn_fifo_channel
